gray2bin_sched: RTL and testbench

GRAY2BIN_SCHED -- requirements
Module: gray2bin_sched

---
 rtl/gray2bin_pkg.sv | 10 +
 rtl/gray2bin_bitstep.sv | 8 +
 rtl/gray2bin_sched.sv | 119 +++++++++++
 tb/tb_gray2bin_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray2bin_pkg.sv
// Shared types for the gray-to-binary conversion scheduler.
package gray2bin_pkg;
   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/gray2bin_bitstep.sv
// One step of gray-to-binary decode: bin[i] = bin[i+1] ^ gray[i].
module gray2bin_bitstep (
   input  logic prev,
   input  logic gray,
   output logic bin
);
   assign bin = prev ^ gray;
endmodule

// File: rtl/gray2bin_sched.sv
// Two-requester round-robin gray-to-binary converter, serial MSB-first by default.
// Define GRAY2BIN_SCHED_FAST_EN to decode the whole word in a single CONV cycle.
module gray2bin_sched
   import gray2bin_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] gray0,
   input  logic             req1,
   input  logic [WIDTH-1:0] gray1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic [WIDTH-1:0] bin,
   output logic             bin_valid,
   output logic             bin_id
);
   state_t           state;
   logic             favour;
   logic             id_q;
   logic [WIDTH-1:0] gray_q;
   logic [WIDTH-1:0] result;
   logic             last_step;
   logic             any_req;
   logic             pick;

   // On a tie the requester not granted last wins.
   always_comb begin
      any_req = req0 | req1;
      pick    = (req0 && req1) ? favour : req1;
   end

`ifdef GRAY2BIN_SCHED_FAST_EN
   logic [WIDTH:0] chain;

   assign chain[WIDTH] = 1'b0;
   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      gray2bin_bitstep u_step (
         .prev (chain[i+1]),
         .gray (gray_q[i]),
         .bin  (chain[i])
      );
   end
   assign result    = chain[WIDTH-1:0];
   assign last_step = 1'b1;
`else
   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-2:0] work;
   logic [IDX_W-1:0] idx;
   logic             step_bit;

   // work holds the bits decoded so far; its LSB is the previous (higher) binary bit.
   gray2bin_bitstep u_step (
      .prev (work[0]),
      .gray (gray_q[idx]),
      .bin  (step_bit)
   );
   assign result    = {work, step_bit};
   assign last_step = (idx == '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         favour    <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         busy      <= 1'b0;
         bin       <= '0;
         bin_valid <= 1'b0;
         bin_id    <= 1'b0;
      end else begin
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         bin_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gray_q <= pick ? gray1 : gray0;
                  id_q   <= pick;
                  gnt0   <= ~pick;
                  gnt1   <= pick;
                  favour <= ~pick;
`ifndef GRAY2BIN_SCHED_FAST_EN
                  work   <= '0;
                  idx    <= IDX_W'(WIDTH - 1);
`endif
                  busy   <= 1'b1;
                  state  <= CONV;
               end
            end
            CONV: begin
`ifndef GRAY2BIN_SCHED_FAST_EN
               work <= result[WIDTH-2:0];
               idx  <= idx - 1'b1;
`endif
               if (last_step) begin
                  bin       <= result;
                  bin_id    <= id_q;
                  bin_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gray2bin_sched.sv
// Randomised self-checking bench for gray2bin_sched against a cycle-count scheduler model.
module tb_gray2bin_sched;
   localparam int W = 4;
`ifdef GRAY2BIN_SCHED_FAST_EN
   localparam int LAT = 1;
`else
   localparam int LAT = W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [W-1:0] gray0 = '0;
   logic [W-1:0] gray1 = '0;
   logic         gnt0, gnt1, busy, bin_valid, bin_id;
   logic [W-1:0] bin;

   always #5 clk = ~clk;

   gray2bin_sched #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .gray0     (gray0),
      .req1      (req1),
      .gray1     (gray1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .busy      (busy),
      .bin       (bin),
      .bin_valid (bin_valid),
      .bin_id    (bin_id)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // expected outputs for the current cycle
   logic         e_gnt0, e_gnt1, e_busy, e_valid, e_id;
   logic [W-1:0] e_bin;
   // model: cycles left in the current job (0 = idle), tie pointer, job contents
   int           m_left = 0;
   logic         m_fav = 1'b0;
   logic         m_id = 1'b0;
   logic [W-1:0] m_gray = '0;

   function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = g;
      for (int k = 1; k < W; k++) b = b ^ (g >> k);
      return b;
   endfunction

   // Advance one clock and predict the outputs visible after that edge.
   task automatic tick();
      logic         p0, p1, pr, w;
      logic [W-1:0] g0, g1;
      p0 = req0; p1 = req1; pr = rst; g0 = gray0; g1 = gray1;
      @(posedge clk);
      #1;
      cyc++;
      e_gnt0  = 1'b0;
      e_gnt1  = 1'b0;
      e_valid = 1'b0;
      if (pr) begin
         m_left = 0;
         m_fav  = 1'b0;
         e_bin  = '0;
         e_id   = 1'b0;
      end else if (m_left == 0) begin
         if (p0 || p1) begin
            w      = (p0 && p1) ? m_fav : p1;
            m_fav  = ~w;
            m_id   = w;
            m_gray = w ? g1 : g0;
            e_gnt0 = ~w;
            e_gnt1 = w;
            m_left = LAT + 1;
         end
      end else begin
         m_left--;
         if (m_left == 1) begin
            e_valid = 1'b1;
            e_bin   = ref_bin(m_gray);
            e_id    = m_id;
         end
      end
      e_busy = (m_left != 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== '0) begin
            bad++;
            $display("FAIL reset cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, 9'b0);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int nval = 0;
      logic [W-1:0] got = '0;
      do_reset();
      req0 = 1'b1; gray0 = 4'b1101;
      for (int i = 0; i < LAT + 4; i++) begin
         tick();
         total++;
         if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin}) begin
            bad++;
            $display("FAIL single cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin});
         end
         if (gnt0) req0 = 1'b0;
         if (bin_valid) begin nval++; got = bin; end
      end
      total++;
      if (nval != 1 || got !== 4'b1001) begin
         bad++;
         $display("FAIL single_result got=%b x%0d want=1001 x1", got, nval);
      end
   endtask

   task automatic test_tie();
      logic [W:0] res_q[$];
      do_reset();
      req0 = 1'b1; gray0 = 4'b1111;
      req1 = 1'b1; gray1 = 4'b0001;
      for (int i = 0; i < 2 * (LAT + 2) + 3; i++) begin
         tick();
         total++;
         if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin}) begin
            bad++;
            $display("FAIL tie cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin});
         end
         if (gnt0) req0 = 1'b0;
         if (gnt1) req1 = 1'b0;
         if (bin_valid) res_q.push_back({bin_id, bin});
      end
      total++;
      if (res_q.size() != 2) begin
         bad++;
         $display("FAIL tie_count got=%0d want=2", res_q.size());
      end else if (res_q[0] !== 5'b0_1010 || res_q[1] !== 5'b1_0001) begin
         bad++;
         $display("FAIL tie_order got=%b,%b want=01010,10001", res_q[0], res_q[1]);
      end
   endtask

   task automatic test_exhaustive();
      int ngnt = 0;
      int nval = 0;
      do_reset();
      for (int g = 0; g < (1 << W); g++) begin
         req1 = 1'b1; gray1 = W'(g);
         for (int i = 0; i < LAT + 2; i++) begin
            tick();
            total++;
            if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin}) begin
               bad++;
               $display("FAIL exhaustive g=%0d cyc=%0d got=%b want=%b", g, cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin});
            end
            if (gnt1) begin req1 = 1'b0; ngnt++; end
            if (bin_valid) nval++;
         end
      end
      total++;
      if (ngnt != (1 << W) || nval != (1 << W)) begin
         bad++;
         $display("FAIL exhaustive_counts gnt=%0d valid=%0d want=%0d each", ngnt, nval, 1 << W);
      end
   endtask

   task automatic test_reset_mid();
      int nval = 0;
      do_reset();
      req0 = 1'b1; gray0 = W'($urandom);
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin}) begin
            bad++;
            $display("FAIL abort_pre cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin});
         end
         if (gnt0) req0 = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== '0) begin
         bad++;
         $display("FAIL abort_reset cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, 9'b0);
      end
      req0 = 1'b1; gray0 = W'($urandom);
      for (int i = 0; i < LAT + 3; i++) begin
         tick();
         total++;
         if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin}) begin
            bad++;
            $display("FAIL abort_post cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin});
         end
         if (gnt0) req0 = 1'b0;
         if (bin_valid) nval++;
      end
      total++;
      if (nval != 1) begin
         bad++;
         $display("FAIL abort_fresh valid=%0d want=1", nval);
      end
   endtask

   task automatic test_alternate();
      int   gq[$];
      logic raised0 = 1'b0;
      do_reset();
      req1 = 1'b1; gray1 = W'($urandom);
      for (int i = 0; i < 3 * (LAT + 2) + 2; i++) begin
         tick();
         total++;
         if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin}) begin
            bad++;
            $display("FAIL alternate cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin});
         end
         if (gnt0) begin gq.push_back(0); req0 = 1'b0; end
         if (gnt1) begin
            gq.push_back(1);
            if (!raised0) begin req0 = 1'b1; gray0 = W'($urandom); raised0 = 1'b1; end
         end
      end
      req1 = 1'b0;
      total++;
      if (gq.size() < 3) begin
         bad++;
         $display("FAIL alternate_count got=%0d want>=3", gq.size());
      end else if (gq[0] != 1 || gq[1] != 0 || gq[2] != 1) begin
         bad++;
         $display("FAIL alternate_order got=%0d%0d%0d want=101", gq[0], gq[1], gq[2]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i < 380) begin
            if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; gray0 = W'($urandom); end
            if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; gray1 = W'($urandom); end
         end
         tick();
         total++;
         if ({gnt0, gnt1, busy, bin_valid, bin_id, bin} !== {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin}) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b want=%b", cyc, {gnt0, gnt1, busy, bin_valid, bin_id, bin}, {e_gnt0, e_gnt1, e_busy, e_valid, e_id, e_bin});
         end
         // occasionally keep req up after its grant so it is taken as a new request
         if (gnt0 && (i >= 380 || $urandom_range(0, 3) != 0)) req0 = 1'b0;
         if (gnt1 && (i >= 380 || $urandom_range(0, 3) != 0)) req1 = 1'b0;
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_exhaustive();
      test_reset_mid();
      test_alternate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
